// File: rtl/debounce_edge.sv
// debounce_edge: N_STABLE-cycle level filter with one-cycle rise/fall strobes.
// Define DEBOUNCE_EDGE_SYNC_EN to add a 2-flop synchronizer ahead of the FSM.
module debounce_edge #(
  parameter int unsigned N_STABLE = 8,
  parameter int unsigned CNT_W    = $clog2(N_STABLE)
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_d,
  input  logic i_en,
  output logic o_q,
  output logic o_rise,
  output logic o_fall,
  output logic o_busy
);

  typedef enum logic [1:0] {
    S_LOW,
    S_CHK_H,
    S_HIGH,
    S_CHK_L
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_STABLE - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             d;

`ifdef DEBOUNCE_EDGE_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], i_d};
    end
  end

  assign d = sync[1];
`else
  assign d = i_d;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= S_LOW;
      cnt    <= '0;
      o_q    <= 1'b0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
      o_busy <= 1'b0;
    end else begin
      o_rise <= 1'b0;
      o_fall <= 1'b0;
      unique case (state)
        S_LOW: begin
          if (i_en && d) begin
            state  <= S_CHK_H;
            cnt    <= ONE;
            o_busy <= 1'b1;
          end
        end
        S_CHK_H: begin
          if (!i_en || !d) begin
            state  <= S_LOW;
            cnt    <= '0;
            o_busy <= 1'b0;
          end else if (cnt == LAST) begin
            state  <= S_HIGH;
            cnt    <= '0;
            o_q    <= 1'b1;
            o_rise <= 1'b1;
            o_busy <= 1'b0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        S_HIGH: begin
          if (i_en && !d) begin
            state  <= S_CHK_L;
            cnt    <= ONE;
            o_busy <= 1'b1;
          end
        end
        S_CHK_L: begin
          if (!i_en || d) begin
            state  <= S_HIGH;
            cnt    <= '0;
            o_busy <= 1'b0;
          end else if (cnt == LAST) begin
            state  <= S_LOW;
            cnt    <= '0;
            o_q    <= 1'b0;
            o_fall <= 1'b1;
            o_busy <= 1'b0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state  <= S_LOW;
          cnt    <= '0;
          o_q    <= 1'b0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_edge.sv
// tb_debounce_edge: directed scoreboard bench for debounce_edge.
// Expected {q,rise,fall,busy} are queued per tick and popped LAT ticks later.
module tb_debounce_edge;

  localparam int unsigned N = 8;
`ifdef DEBOUNCE_EDGE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rstn;
  logic d;
  logic en;
  logic q, rise, fall, busy;

  logic [3:0] sb[$];
  string      tq[$];
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  debounce_edge #(.N_STABLE(N)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .i_d    (d),
    .i_en   (en),
    .o_q    (q),
    .o_rise (rise),
    .o_fall (fall),
    .o_busy (busy)
  );

  task automatic check(input logic [3:0] e, input string tag);
    logic [3:0] o;
    o = {q, rise, fall, busy};
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed qrfb=%b expected qrfb=%b", tag, o, e);
    end
  endtask

  task automatic tick(input logic dv, input logic ev,
                      input logic [3:0] e, input string tag);
    d  = dv;
    en = ev;
    sb.push_back(e);
    tq.push_back(tag);
    @(posedge clk);
    #1;
    if (sb.size() > LAT) check(sb.pop_front(), tq.pop_front());
  endtask

  task automatic flush();
    sb.delete();
    tq.delete();
  endtask

  initial begin
    rstn = 1'b0;
    d    = 1'b1;
    en   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check(4'b0000, "reset");
    end
    rstn = 1'b1;
    flush();

    // clean rise
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b1, 4'b0000, "idle");
    for (int i = 1; i <= 20; i++) begin
      if (i < N)       tick(1'b1, 1'b1, 4'b0001, "rise_busy");
      else if (i == N) tick(1'b1, 1'b1, 4'b1100, "rise_accept");
      else             tick(1'b1, 1'b1, 4'b1000, "rise_hold");
    end

    // clean fall
    for (int i = 1; i <= N; i++) begin
      if (i < N) tick(1'b0, 1'b1, 4'b1001, "fall_busy");
      else       tick(1'b0, 1'b1, 4'b0010, "fall_accept");
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 4'b0000, "fall_hold");

    // glitch of N-1 cycles
    for (int i = 0; i < N - 1; i++) tick(1'b1, 1'b1, 4'b0001, "glitch_busy");
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 4'b0000, "glitch_reject");

`ifndef DEBOUNCE_EDGE_SYNC_EN
    // disabled filter ignores a high input
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 4'b0000, "en_off");
    tick(1'b0, 1'b1, 4'b0000, "en_idle");

    // enable abort mid-count
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 4'b0001, "abort_busy");
    tick(1'b1, 1'b0, 4'b0000, "abort_drop");
    for (int i = 1; i <= N; i++) begin
      if (i < N) tick(1'b1, 1'b1, 4'b0001, "abort_recount");
      else       tick(1'b1, 1'b1, 4'b1100, "abort_rise");
    end
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b1, 4'b1000, "abort_hold");

    // abort in the high state keeps q=1, no fall
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 4'b1001, "abortl_busy");
    tick(1'b0, 1'b0, 4'b1000, "abortl_drop");
    for (int i = 1; i <= N; i++) begin
      if (i < N) tick(1'b0, 1'b1, 4'b1001, "abortl_recount");
      else       tick(1'b0, 1'b1, 4'b0010, "abortl_fall");
    end
    tick(1'b0, 1'b1, 4'b0000, "abortl_hold");
`endif

    // reset asserted mid-count
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 4'b0001, "pre_rst_busy");
    rstn = 1'b0;
    #1;
    check(4'b0000, "mid_reset_now");
    flush();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check(4'b0000, "mid_reset_hold");
    end
    rstn = 1'b1;

    // fresh rise after reset starts from zero
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b1, 4'b0000, "post_idle");
    for (int i = 1; i <= N; i++) begin
      if (i < N) tick(1'b1, 1'b1, 4'b0001, "post_busy");
      else       tick(1'b1, 1'b1, 4'b1100, "post_rise");
    end
    for (int i = 0; i < LAT + 2; i++) tick(1'b1, 1'b1, 4'b1000, "post_hold");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_edge.md
Name: debounce_edge

Overview:
- Level debouncer and edge detector that consumes the registered single-bit level produced by the upstream dff stage (its o_q drives i_d here).
- Accepts a new level only after it has been stable for N_STABLE consecutive clock edges.
- Outputs the filtered level plus one-cycle rise/fall strobes for downstream control logic.

Parameters:
- N_STABLE, 8, consecutive sampling edges i_d must hold a new value before it is accepted; legal range 2..65535.
- CNT_W, $clog2(N_STABLE), stability counter width (derived; do not override).

Ports:
- i_clk  input  1  system clock, rising-edge active.
- i_rstn  input  1  asynchronous active-low reset.
- i_d  input  1  level from upstream dff stage.
- i_en  input  1  filter enable; low aborts any pending change.
- o_q  output  1  debounced level.
- o_rise  output  1  one-cycle pulse on accepted 0->1.
- o_fall  output  1  one-cycle pulse on accepted 1->0.
- o_busy  output  1  high while a candidate change is being counted.

Behaviour:
- Clock and reset:
  - One clock, i_clk.
  - Reset is asynchronous, active-low on i_rstn.
  - While i_rstn=0: state=S_LOW, cnt=0, o_q=0, o_rise=0, o_fall=0, o_busy=0.
  - Reset deassertion takes effect at the next rising edge.
- FSM states: S_LOW, S_CHK_H, S_HIGH, S_CHK_L; all outputs registered.
- S_LOW (o_q=0):
  - i_en=1 and i_d=1 -> S_CHK_H, cnt=1.
  - Else stay.
- S_CHK_H (o_q=0, o_busy=1):
  - i_en=0 or i_d=0 -> S_LOW, cnt=0, no pulse.
  - i_d=1 and cnt==N_STABLE-1 -> S_HIGH, o_q=1, o_rise=1 for exactly one cycle, cnt=0.
  - Otherwise cnt=cnt+1.
- S_HIGH and S_CHK_L: mirror images of S_LOW and S_CHK_H with polarity inverted. Acceptance drives o_q=0 and pulses o_fall.
- Latency: i_d stable from sampling edge k through edge k+N_STABLE-1 -> o_q and the strobe update on edge k+N_STABLE-1, i.e. the N_STABLE-th sampling edge.
- Glitches: a pulse on i_d shorter than N_STABLE cycles produces no change on o_q and no strobe. The counter restarts from 1 on the next qualifying sample.
- Strobes:
  - o_rise and o_fall are never high in the same cycle.
  - Each strobe is high only in the cycle immediately after its transition edge.
- o_busy is high exactly when state is S_CHK_H or S_CHK_L.
- i_en=0:
  - Forces any CHK state back to its stable state.
  - o_q holds its value; no strobes are generated.
- cnt never exceeds N_STABLE-1; no wrap-around is possible.
- Reset asserted mid-count: immediate return to reset values; the partial count is discarded and no strobe is issued.

Optional Feature:
- Macro: DEBOUNCE_EDGE_SYNC_EN.
- Defined:
  - i_d passes through a two-flop synchronizer (both flops reset to 0 by i_rstn) before the FSM.
  - Total latency from a stable i_d to o_q grows by 2 cycles.
  - Permits asynchronous sources on i_d.
- Undefined:
  - i_d feeds the FSM directly.
  - The upstream dff stage is the only register ahead of the filter.

Test Plan:
- Reset: i_rstn=0 for 3 cycles with i_d=1 -> o_q=0, o_rise=0, o_fall=0, o_busy=0 throughout.
- Clean rise, N_STABLE=8, i_en=1: i_d 0->1 held 20 cycles -> o_busy high 7 cycles, o_q=1 on the 8th sampling edge, o_rise high exactly 1 cycle, o_fall stays 0.
- Glitch rejection: from o_q=0, i_d=1 for 7 cycles then 0 -> o_q stays 0, no o_rise, o_busy falls when i_d returns to 0.
- Clean fall: from o_q=1, i_d=0 held 8 cycles -> o_q=0 on the 8th edge, o_fall 1 cycle.
- Enable abort and mid-count reset:
  - i_d=1 for 5 cycles, then i_en=0 for 1 cycle -> state returns to S_LOW, count restarts, first o_rise appears 8 edges after i_en returns high.
  - Separately, assert i_rstn=0 at count 6 -> all outputs 0 immediately.
- DEBOUNCE_EDGE_SYNC_EN defined: repeat the clean-rise scenario -> o_q and o_rise occur 2 cycles later than in the undefined build.
